// File: rtl/window_pkg.sv
// Shared window definitions for the 3x3 kernel byte selector/demux pair.
// Holds widths, the packed window type and small mask helpers.
package window_pkg;

   localparam int DATA_W    = 8;
   localparam int NUM_SLOTS = 9;
   localparam int SEL_W     = 5;
   localparam int IDX_W     = 4;
   localparam int CNT_W     = 4;
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SLOTS - 1);

   typedef logic [0:NUM_SLOTS-1][DATA_W-1:0] window_t;

   // One-hot mask bit for a slot; bit k of the mask belongs to slot k.
   function automatic logic [NUM_SLOTS-1:0] slot_bit(input logic [IDX_W-1:0] idx);
      logic [NUM_SLOTS-1:0] one;
      one = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] m);
      logic [CNT_W-1:0] cnt;
      cnt = {CNT_W{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cnt = cnt + {{(CNT_W-1){1'b0}}, m[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/window_fill_tracker.sv
// Written-slot mask for the fill buffer: set one slot per cycle, bulk clear,
// full flag and popcount.
module window_fill_tracker
   import window_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 set_en,
   input  logic [IDX_W-1:0]     set_idx,
   input  logic                 clear,
   output logic [NUM_SLOTS-1:0] mask,
   output logic                 fill_full,
   output logic [CNT_W-1:0]     fill_count
);

   logic [NUM_SLOTS-1:0] mask_r;

   // Clear wins over set: a completing byte is already folded into the copied window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_r <= {NUM_SLOTS{1'b0}};
      end else if (clear) begin
         mask_r <= {NUM_SLOTS{1'b0}};
      end else if (set_en) begin
         mask_r <= mask_r | slot_bit(set_idx);
      end else begin
         mask_r <= mask_r;
      end
   end

   assign mask       = mask_r;
   assign fill_full  = (mask_r == {NUM_SLOTS{1'b1}});
   assign fill_count = popcount(mask_r);

endmodule

// File: rtl/window_demux9.sv
// Assembles addressed bytes into a 3x3 window; a fill buffer loads the next
// window while the output buffer waits on the consumer handshake.
module window_demux9
   import window_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output window_t           win_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [CNT_W-1:0]  fill_count,
   output logic [SEL_W-1:0]  last_sel,
   output logic              err_sel
);

   logic [NUM_SLOTS-1:0] mask;
   logic                 fill_full;
   logic                 accept;
   logic                 sel_ok;
   logic                 write_en;
   logic                 out_free;
   logic                 completes;
   logic                 win_load;
   logic [IDX_W-1:0]     slot;
   window_t              fill_buf;
   window_t              next_fill;
   window_t              win_data_r;
   logic                 win_valid_r;
   logic [SEL_W-1:0]     last_sel_r;
   logic                 err_sel_r;

   assign in_ready  = !fill_full;
   assign accept    = in_valid & in_ready;
   assign sel_ok    = (in_sel <= SEL_MAX);
   assign write_en  = accept & sel_ok;
   assign slot      = in_sel[IDX_W-1:0];
   assign out_free  = !win_valid_r | win_ready;
   assign completes = write_en & ((mask | slot_bit(slot)) == {NUM_SLOTS{1'b1}});
   // Load on a fresh completion or to release a window parked in the fill buffer.
   assign win_load  = out_free & (completes | fill_full);

   window_fill_tracker u_tracker (
      .clk        (clk),
      .rst        (rst),
      .set_en     (write_en),
      .set_idx    (slot),
      .clear      (win_load),
      .mask       (mask),
      .fill_full  (fill_full),
      .fill_count (fill_count)
   );

   // Fill buffer contents including the byte accepted this cycle.
   always_comb begin
      next_fill = fill_buf;
      if (write_en) begin
         next_fill[slot] = in_data;
      end else begin
         next_fill = fill_buf;
      end
   end

   // Fill buffer, output buffer and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_buf    <= {(NUM_SLOTS*DATA_W){1'b0}};
         win_data_r  <= {(NUM_SLOTS*DATA_W){1'b0}};
         win_valid_r <= 1'b0;
         last_sel_r  <= {SEL_W{1'b0}};
         err_sel_r   <= 1'b0;
      end else begin
         fill_buf  <= next_fill;
         err_sel_r <= accept & !sel_ok;
         if (accept) begin
            last_sel_r <= in_sel;
         end else begin
            last_sel_r <= last_sel_r;
         end
         if (win_load) begin
            win_data_r  <= next_fill;
            win_valid_r <= 1'b1;
         end else if (win_ready) begin
            win_data_r  <= win_data_r;
            win_valid_r <= 1'b0;
         end else begin
            win_data_r  <= win_data_r;
            win_valid_r <= win_valid_r;
         end
      end
   end

   assign win_data  = win_data_r;
   assign win_valid = win_valid_r;
   assign last_sel  = last_sel_r;
   assign err_sel   = err_sel_r;

endmodule

// File: tb/tb_window_demux9.sv
// Self-checking bench for window_demux9: directed scenarios plus random
// traffic compared against a queue-of-windows reference model.
module tb_window_demux9;
   import window_pkg::*;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] in_data;
   logic [SEL_W-1:0]  in_sel;
   logic              in_valid;
   logic              in_ready;
   window_t           win_data;
   logic              win_valid;
   logic              win_ready;
   logic [CNT_W-1:0]  fill_count;
   logic [SEL_W-1:0]  last_sel;
   logic              err_sel;

   int checks_total;
   int checks_passed;

   // Reference model: windows awaiting the consumer, oldest first. Entry 0 is
   // on the output; a second entry is a completed window parked in the fill buffer.
   window_t    m_q[$];
   window_t    m_bytes;
   window_t    m_shown;
   logic [8:0] m_written;
   logic [4:0] m_last;
   logic       m_err;
   int         peak_hits;

   window_demux9 dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .fill_count (fill_count),
      .last_sel   (last_sel),
      .err_sel    (err_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks_total++;
      if (got === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_bytes   = '0;
      m_shown   = '0;
      m_written = 9'd0;
      m_last    = 5'd0;
      m_err     = 1'b0;
   endtask

   task automatic compare_all();
      int exp_cnt;
      exp_cnt = (m_q.size() == 2) ? 9 : $countones(m_written);
      check("win_valid",  {71'd0, win_valid},  {71'd0, m_q.size() > 0});
      check("win_data",   win_data,            m_shown);
      check("in_ready",   {71'd0, in_ready},   {71'd0, m_q.size() < 2});
      check("fill_count", {68'd0, fill_count}, 72'(exp_cnt));
      check("last_sel",   {67'd0, last_sel},   {67'd0, m_last});
      check("err_sel",    {71'd0, err_sel},    {71'd0, m_err});
   endtask

   task automatic step(input logic v, input logic [4:0] s, input logic [7:0] d, input logic r);
      bit hs;
      bit acc;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      win_ready = r;
      @(posedge clk);
      hs  = (m_q.size() > 0) && r;
      acc = v && (m_q.size() < 2);
      if (hs) void'(m_q.pop_front());
      m_err = 1'b0;
      if (acc) begin
         m_last = s;
         if (s <= 5'd8) begin
            m_bytes[int'(s)]   = d;
            m_written[int'(s)] = 1'b1;
            if (m_written == 9'h1FF) begin
               m_q.push_back(m_bytes);
               m_written = 9'd0;
            end
         end else begin
            m_err = 1'b1;
         end
      end
      if (m_q.size() > 0) m_shown = m_q[0];
      #1;
      if (fill_count == 4'd9) peak_hits++;
      compare_all();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      win_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      compare_all();
      rst = 1'b0;
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      peak_hits     = 0;
      in_data   = 8'd0;
      in_sel    = 5'd0;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      model_clear();
      do_reset();

      // In-order fill with consumer ready.
      for (int k = 0; k < 9; k++) step(1'b1, 5'(k), 8'(8'h10 + k), 1'b1);
      check("seq_slot3", {64'd0, win_data[3]}, 72'h13);
      step(1'b0, 5'd0, 8'd0, 1'b1);

      // Reverse order with slot 4 rewritten.
      peak_hits = 0;
      for (int k = 8; k >= 0; k--) begin
         if (k == 4) step(1'b1, 5'd4, 8'hAA, 1'b0);
         step(1'b1, 5'(k), 8'(8'h20 + k), 1'b0);
      end
      check("rev_slot4_last", {64'd0, win_data[4]}, 72'h24);
      check("fill_peak_once", 72'(peak_hits), 72'd0);
      step(1'b1, 5'd4, 8'hAA, 1'b1);
      step(1'b1, 5'd4, 8'h55, 1'b1);
      for (int k = 0; k < 9; k++) if (k != 4) step(1'b1, 5'(k), 8'(8'h40 + k), 1'b1);
      check("rewrite_slot4", {64'd0, win_data[4]}, 72'h55);

      // Stall: two windows, consumer not ready.
      step(1'b0, 5'd0, 8'd0, 1'b1);
      for (int k = 0; k < 18; k++) step(1'b1, 5'(k % 9), 8'(8'h60 + k), 1'b0);
      check("stall_ready", {71'd0, in_ready}, 72'd0);
      for (int k = 0; k < 3; k++) step(1'b1, 5'd2, 8'hEE, 1'b0);
      step(1'b0, 5'd0, 8'd0, 1'b1);
      check("released_slot0", {64'd0, win_data[0]}, 72'h69);
      step(1'b0, 5'd0, 8'd0, 1'b0);
      step(1'b0, 5'd0, 8'd0, 1'b1);

      // Out-of-range slot index.
      step(1'b1, 5'd3, 8'h33, 1'b1);
      step(1'b1, 5'd12, 8'hCC, 1'b1);
      check("err_last_sel", {67'd0, last_sel}, 72'd12);
      step(1'b0, 5'd0, 8'd0, 1'b1);

      // Reset mid-fill, then a clean window.
      for (int k = 0; k < 5; k++) step(1'b1, 5'(k), 8'hF0, 1'b1);
      do_reset();
      for (int k = 0; k < 9; k++) step(1'b1, 5'(k), 8'(8'h80 + k), 1'b1);
      check("clean_slot2", {64'd0, win_data[2]}, 72'h82);

      // Continuous stream, 4 windows.
      for (int w = 0; w < 4; w++)
         for (int k = 0; k < 9; k++) step(1'b1, 5'(8 - k), 8'($urandom_range(0, 255)), 1'b1);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 10)),
              8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
